nonce_sweep_ctrl: RTL

Sequencing controller that drives the `sha256_double` engine across a nonce range without per-hash CPU involvement. It takes a base 80-byte header, a 256-bit target and an inclusive nonce range. For each nonce it inserts the nonce into the header, issues one engine start, compares the returned hash against the target, and stops on the first hit or when the range is exhausted. It sits between the AXI register file (configuration and status) and the engine's `start/ready/hash_out/hash_valid` port.

---
 rtl/miner_pkg.sv | 22 ++
 rtl/nonce_sweep_ctrl_if.sv | 27 ++
 rtl/nonce_sweep_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared types, widths and helpers for the nonce sweep path.
package miner_pkg;

  localparam int HDR_W   = 640;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } sweep_state_t;

  // The header carries the nonce little-endian in bytes 76..79.
  function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Start/result handshake between the sweep controller and the double-SHA engine.
interface nonce_sweep_ctrl_if;
  import miner_pkg::*;

  logic              eng_start;
  logic [HDR_W-1:0]  eng_header;
  logic              eng_ready;
  logic [HASH_W-1:0] eng_hash;
  logic              eng_hash_valid;

  modport master (
    output eng_start,
    output eng_header,
    input  eng_ready,
    input  eng_hash,
    input  eng_hash_valid
  );

  modport slave (
    input  eng_start,
    input  eng_header,
    output eng_ready,
    output eng_hash,
    output eng_hash_valid
  );

endinterface

// File: rtl/nonce_sweep_ctrl.sv
// Walks the engine across an inclusive, possibly wrapping nonce range and
// stops on the first hash <= target, on range exhaustion, or on abort.
//
// state | meaning
// IDLE  | no sweep since reset
// ISSUE | waiting for eng_ready to launch the current nonce
// WAIT  | engine running, waiting for eng_hash_valid
// CHECK | compare captured hash against target, pick next nonce
// DRAIN | aborted while engine busy, swallowing its result
// DONE  | sweep over, status held until the next start
module nonce_sweep_ctrl
  import miner_pkg::*;
#(
  parameter int CNT_W = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_start,
  input  logic                cmd_abort,
  input  logic [HDR_W-1:0]    header_base,
  input  logic [HASH_W-1:0]   target,
  input  logic [NONCE_W-1:0]  nonce_first,
  input  logic [NONCE_W-1:0]  nonce_last,
  nonce_sweep_ctrl_if.master  eng,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic                aborted,
  output logic [NONCE_W-1:0]  cur_nonce,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [HASH_W-1:0]   last_hash,
  output logic [CNT_W-1:0]    hash_count
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]               state;
  logic [HDR_W-1:NONCE_W]   hdr_q;
  logic [HASH_W-1:0]        target_q;
  logic [NONCE_W-1:0]       last_q;
  logic                     hit;
  logic                     start_ok;

  // The nonce field of the base header is always overwritten.
  logic unused_hdr_nonce;
  assign unused_hdr_nonce = ^header_base[NONCE_W-1:0];

  assign hit      = (last_hash <= target_q);
  assign start_ok = cmd_start && !cmd_abort;

  assign busy  = (state == S_ISSUE) || (state == S_WAIT) ||
                 (state == S_CHECK) || (state == S_DRAIN);
  assign done  = (state == S_DONE);

  // An abort in ISSUE must not launch a hash that nobody would drain.
  assign eng.eng_start  = (state == S_ISSUE) && eng.eng_ready && !cmd_abort;
  assign eng.eng_header = {hdr_q, bswap32(cur_nonce)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hdr_q       <= '0;
      target_q    <= '0;
      last_q      <= '0;
      cur_nonce   <= '0;
      found       <= 1'b0;
      aborted     <= 1'b0;
      found_nonce <= '0;
      last_hash   <= '0;
      hash_count  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            hdr_q      <= header_base[HDR_W-1:NONCE_W];
            target_q   <= target;
            last_q     <= nonce_last;
            cur_nonce  <= nonce_first;
            found      <= 1'b0;
            aborted    <= 1'b0;
            hash_count <= '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_abort) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (eng.eng_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmd_abort) begin
            // A result landing on the abort cycle is the one we would drain.
            if (eng.eng_hash_valid) begin
              aborted <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_DRAIN;
            end
          end else if (eng.eng_hash_valid) begin
            last_hash  <= eng.eng_hash;
            hash_count <= hash_count + 1'b1;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= cur_nonce;
            state       <= S_DONE;
          end else if (cmd_abort) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (cur_nonce == last_q) begin
            state <= S_DONE;
          end else begin
            cur_nonce <= cur_nonce + 32'd1;
            state     <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (eng.eng_hash_valid) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
